stream_demux_1to2: RTL and testbench

//  Routes one valid/ready input stream to one of two output streams, selected by in_sel.
//  in_sel is sampled on the first beat of each packet and held until the beat carrying in_last.

---
 rtl/stream_pkg.sv | 18 +
 rtl/stream_reg_slice.sv | 64 ++++++
 rtl/stream_demux_1to2.sv | 138 +++++++++++++
 tb/tb_stream_demux_1to2.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the 1:2 packet stream demultiplexer.
//   state_t      : demux packet-routing state (IDLE / LOCK0 / LOCK1)
//   PORT0, PORT1 : encodings of the destination select
// -----------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no packet open, in_sel chooses the destination
        LOCK0 = 2'd1,   // packet open towards out0
        LOCK1 = 2'd2    // packet open towards out1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage : stream_pkg

// File: rtl/stream_reg_slice.sv
// -----------------------------------------------------------------------------
// stream_reg_slice
// One-entry valid/ready register stage. A new beat may be loaded in the same
// cycle the held beat is popped, so back-to-back beats flow at full rate.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid_i    : upstream beat valid
//   in_ready_o    : stage can take a beat (empty, or being popped this cycle)
//   in_data_i     : upstream payload (W bits)
//   out_valid_o   : stage holds a beat
//   out_ready_i   : downstream sink ready
//   out_data_o    : held payload (W bits)
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; valid never depends on ready, and a held beat stays stable while
// valid=1 and ready=0.
// -----------------------------------------------------------------------------
module stream_reg_slice #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         load;
    logic         pop;

    assign in_ready_o = !valid_q || out_ready_i;
    assign load       = in_valid_i && in_ready_o;
    assign pop        = valid_q && out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            // A load wins over a pop: the slot is refilled in the same cycle.
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule : stream_reg_slice

// File: rtl/stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// stream_demux_1to2
// Routes one valid/ready packet stream to out0 or out1. The destination is
// taken from in_sel on the first beat of a packet and locked until the beat
// carrying in_last. Each output has a one-entry register stage.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/
//   in_last/in_sel                 : input stream (in_sel used on first beat)
//   out0_valid/out0_ready/
//   out0_data/out0_last            : output stream 0
//   out1_valid/out1_ready/
//   out1_data/out1_last            : output stream 1
//   pkt_cnt0, pkt_cnt1             : saturating completed-packet counters
//   state_o                        : current routing state (debug visibility)
// -----------------------------------------------------------------------------
module stream_demux_1to2
    import stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_last,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_last,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output state_t            state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic             sel_eff;
    logic             accept;
    logic             s0_in_ready, s1_in_ready;
    logic             s0_in_valid, s1_in_valid;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // The destination is only free to change while no packet is open.
    always_comb begin
        unique case (state_q)
            LOCK0:   sel_eff = PORT0;
            LOCK1:   sel_eff = PORT1;
            default: sel_eff = in_sel;
        endcase
    end

    // Only the selected slice's readiness matters, so a stalled idle output
    // never blocks traffic headed to the other one.
    assign in_ready    = (sel_eff == PORT1) ? s1_in_ready : s0_in_ready;
    assign accept      = in_valid && in_ready;
    assign s0_in_valid = in_valid && (sel_eff == PORT0);
    assign s1_in_valid = in_valid && (sel_eff == PORT1);

    stream_reg_slice #(.W(DATA_W + 1)) u_slice0 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s0_in_valid),
        .in_ready_o  (s0_in_ready),
        .in_data_i   ({in_last, in_data}),
        .out_valid_o (out0_valid),
        .out_ready_i (out0_ready),
        .out_data_o  ({out0_last, out0_data})
    );

    stream_reg_slice #(.W(DATA_W + 1)) u_slice1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_in_valid),
        .in_ready_o  (s1_in_ready),
        .in_data_i   ({in_last, in_data}),
        .out_valid_o (out1_valid),
        .out_ready_i (out1_ready),
        .out_data_o  ({out1_last, out1_data})
    );

    // Packet routing FSM. Single-beat packets never leave IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && !in_last) begin
                        state_q <= (sel_eff == PORT1) ? LOCK1 : LOCK0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (accept && in_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A packet counts as complete when its last beat leaves the output slice.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (out0_valid && out0_ready && out0_last && (cnt0_q != CNT_MAX)) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (out1_valid && out1_ready && out1_last && (cnt1_q != CNT_MAX)) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
    assign state_o  = state_q;

endmodule : stream_demux_1to2

// File: tb/tb_stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1to2
// Directed bench for stream_demux_1to2 built with CNT_W=2 so counter
// saturation is reachable in a few packets; the DUT is reset between sections.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_stream_demux_1to2;
    import stream_pkg::*;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data  = '0;
    logic              in_last  = 1'b0;
    logic              in_sel   = 1'b0;
    logic              out0_valid;
    logic              out0_ready = 1'b0;
    logic [DATA_W-1:0] out0_data;
    logic              out0_last;
    logic              out1_valid;
    logic              out1_ready = 1'b0;
    logic [DATA_W-1:0] out1_data;
    logic              out1_last;
    logic [CNT_W-1:0]  pkt_cnt0;
    logic [CNT_W-1:0]  pkt_cnt1;
    state_t            state_o;

    int n_assert = 0;
    int n_fail   = 0;

    stream_demux_1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1),
        .state_o    (state_o)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic l, input logic s);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_sel   = s;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Safety net: the directed sequence is short, this never fires normally.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Section 1: reset state, async reset mid-packet, recovery
        do_reset();
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out0_data",  32'(out0_data),  32'd0);
        chk("rst_cnt0",       32'(pkt_cnt0),   32'd0);
        chk("rst_cnt1",       32'(pkt_cnt1),   32'd0);
        chk("rst_state",      32'(state_o),    32'(IDLE));

        out1_ready = 1'b0;
        drive(1'b1, 8'h33, 1'b0, 1'b1);
        tick();
        chk("s1_lock1_state", 32'(state_o),    32'(LOCK1));
        chk("s1_out1_valid",  32'(out1_valid), 32'd1);
        chk("s1_out1_data",   32'(out1_data),  32'h33);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("s1_async_out1_valid", 32'(out1_valid), 32'd0);
        chk("s1_async_out0_valid", 32'(out0_valid), 32'd0);
        chk("s1_async_state",      32'(state_o),    32'(IDLE));
        chk("s1_async_cnt1",       32'(pkt_cnt1),   32'd0);
        tick();
        rst = 1'b0;
        out0_ready = 1'b0;
        drive(1'b1, 8'h44, 1'b1, 1'b0);
        tick();
        chk("s1_post_out0_valid", 32'(out0_valid), 32'd1);
        chk("s1_post_out0_data",  32'(out0_data),  32'h44);
        chk("s1_post_out1_valid", 32'(out1_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Section 2: single-beat packet to out1
        do_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 8'hA5, 1'b1, 1'b1);
        #1;
        chk("s2_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("s2_out1_valid", 32'(out1_valid), 32'd1);
        chk("s2_out1_data",  32'(out1_data),  32'hA5);
        chk("s2_out1_last",  32'(out1_last),  32'd1);
        chk("s2_out0_valid", 32'(out0_valid), 32'd0);
        chk("s2_state",      32'(state_o),    32'(IDLE));
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("s2_out1_drained", 32'(out1_valid), 32'd0);
        chk("s2_cnt1",         32'(pkt_cnt1),   32'd1);
        chk("s2_cnt0",         32'(pkt_cnt0),   32'd0);

        // Section 3: select locked for a 4-beat packet while in_sel toggles
        do_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h10 + i), (i == 3), i[0]);
            tick();
            chk($sformatf("s3_out0_valid_%0d", i), 32'(out0_valid), 32'd1);
            chk($sformatf("s3_out0_data_%0d", i),  32'(out0_data),  32'(8'h10 + i));
            chk($sformatf("s3_out0_last_%0d", i),  32'(out0_last),  32'(i == 3));
            chk($sformatf("s3_out1_valid_%0d", i), 32'(out1_valid), 32'd0);
            chk($sformatf("s3_state_%0d", i),      32'(state_o),
                (i == 3) ? 32'(IDLE) : 32'(LOCK0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("s3_out0_drained", 32'(out0_valid), 32'd0);
        chk("s3_cnt0",         32'(pkt_cnt0),   32'd1);
        chk("s3_cnt1",         32'(pkt_cnt1),   32'd0);

        // Section 4: backpressure on out0 with two beats pending
        do_reset();
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h21, 1'b1, 1'b1);   // sel ignored: packet is locked to out0
        #1;
        chk("s4_in_ready_stalled", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("s4_hold_valid_%0d", k), 32'(out0_valid), 32'd1);
            chk($sformatf("s4_hold_data_%0d", k),  32'(out0_data),  32'h20);
            chk($sformatf("s4_hold_ready_%0d", k), 32'(in_ready),   32'd0);
        end
        chk("s4_state_locked", 32'(state_o),    32'(LOCK0));
        chk("s4_out1_valid",   32'(out1_valid), 32'd0);
        out0_ready = 1'b1;
        #1;
        chk("s4_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        chk("s4_second_valid", 32'(out0_valid), 32'd1);
        chk("s4_second_data",  32'(out0_data),  32'h21);
        chk("s4_second_last",  32'(out0_last),  32'd1);
        chk("s4_state_idle",   32'(state_o),    32'(IDLE));
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("s4_drained", 32'(out0_valid), 32'd0);
        chk("s4_cnt0",    32'(pkt_cnt0),   32'd1);

        // Section 5: a full, stalled out1 does not block traffic to out0
        do_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        drive(1'b1, 8'h55, 1'b1, 1'b1);
        tick();
        chk("s5_out1_full", 32'(out1_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h30 + i), (i == 2), 1'b0);
            #1;
            chk($sformatf("s5_in_ready_%0d", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("s5_out0_valid_%0d", i), 32'(out0_valid), 32'd1);
            chk($sformatf("s5_out0_data_%0d", i),  32'(out0_data),  32'(8'h30 + i));
            chk($sformatf("s5_out1_hold_%0d", i),  32'(out1_data),  32'h55);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("s5_out0_drained", 32'(out0_valid), 32'd0);
        chk("s5_cnt0",         32'(pkt_cnt0),   32'd1);
        chk("s5_cnt1_stalled", 32'(pkt_cnt1),   32'd0);
        chk("s5_out1_still",   32'(out1_valid), 32'd1);
        out1_ready = 1'b1;
        tick();
        chk("s5_out1_drained", 32'(out1_valid), 32'd0);
        chk("s5_cnt1",         32'(pkt_cnt1),   32'd1);

        // Section 6: pkt_cnt1 saturates at 3 with CNT_W=2
        do_reset();
        out1_ready = 1'b1;
        chk("s6_cnt1_start", 32'(pkt_cnt1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b1);
            tick();
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            tick();
            chk($sformatf("s6_cnt1_%0d", i), 32'(pkt_cnt1), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        chk("s6_cnt0", 32'(pkt_cnt0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_stream_demux_1to2
